dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the next-generation CPU. It serves load/store requests from the CPU over a req/ready/done handshake and inserts a configurable number of wait states before each response. It replaces the zero-latency combinational data memory, so CPU control logic can be developed against realistic memory timing. Internally it is a word-organised RAM behind a small request state machine.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_ram.sv | 30 +++
 rtl/dmem_responder.sv | 92 +++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
// addr_err is the single definition of a bad access, used by RTL and bench alike.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int WS_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } dmem_req_t;

    // Misaligned byte address, or any bit set above the word-index field.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int addr_bits);
        logic [WORD_W-1:0] hi;
        hi = addr >> (addr_bits + 2);
        return (addr[1:0] != 2'b00) || (hi != '0);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write, registered read.
// The read register can also be cleared synchronously so a failed load reports zero.
module dmem_ram #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic                 re,
    input  logic                 clr,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_BITS)-1];

    // Array contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rdata <= '0;
        else if (re)  rdata <= mem[addr];
        else if (clr) rdata <= '0;
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with a fixed number of wait states ahead of each response.
// Request capture, wait counter and error check sit in front of dmem_ram.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 5,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    localparam logic [WS_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? WS_W'(WAIT_STATES - 1) : '0;

    dmem_state_t          state, state_nx;
    logic [WS_W-1:0]      cnt;
    dmem_req_t            cap, cur;
    logic                 accept, commit, cur_err;
    logic                 ram_we, ram_re, ram_clr;
    logic [ADDR_BITS-1:0] widx;

    // With no wait states the commit edge is the acceptance edge, so the live
    // inputs must feed the RAM directly; otherwise the captured copy does.
    assign cur     = (state == IDLE) ? dmem_req_t'{we: we, addr: addr, wdata: wdata} : cap;
    assign accept  = (state == IDLE) && req;
    assign commit  = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt == '0));
    assign cur_err = addr_err(cur.addr, ADDR_BITS);
    assign widx    = cur.addr[ADDR_BITS+1:2];

    assign ram_we  = commit &&  cur.we && !cur_err;
    assign ram_re  = commit && !cur.we && !cur_err;
    assign ram_clr = commit && !cur.we &&  cur_err;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) state_nx = RESP;
                    else                  state_nx = WAIT;
                end
            end
            WAIT:    if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cap <= cur;
                cnt <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - WS_W'(1);
            end
            if (commit) err <= cur_err;
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == RESP);

    dmem_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (WORD_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (clrn),
        .we    (ram_we),
        .re    (ram_re),
        .clr   (ram_clr),
        .addr  (widx),
        .wdata (cur.wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states), a transaction-level
// model checked every cycle, and directed transactions with literal expectations.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int AB = 5;

    logic        clk  = 1'b0;
    logic        clrn = 1'b0;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        done  [2];
    logic        err   [2];
    logic [31:0] rdata [2];

    int errors = 0;
    int checks = 0;

    dmem_responder #(.ADDR_BITS(AB), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .clrn(clrn), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .ready(ready[0]), .done(done[0]), .rdata(rdata[0]), .err(err[0])
    );

    dmem_responder #(.ADDR_BITS(AB), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .clrn(clrn), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .ready(ready[1]), .done(done[1]), .rdata(rdata[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    function automatic int ws(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: cycle index cyc counts rising edges; a request seen
    // at an edge while free is accepted there, commits WS edges later (done that
    // cycle) and frees the responder one cycle after that.
    int          cyc = 0;
    int          mcur;
    int          free_at   [2];
    int          commit_at [2];
    logic        p_we      [2];
    logic [31:0] p_addr    [2];
    logic [31:0] p_wdata   [2];
    logic [31:0] mem_m     [2][32];
    logic [31:0] exp_rdata [2];
    logic        exp_err   [2];
    logic        me;
    logic [4:0]  midx;

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) mem_m[k][i] = '0;
            free_at[k] = 0; commit_at[k] = -1; exp_rdata[k] = '0; exp_err[k] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge clrn);
            if (!clrn) begin
                for (int k = 0; k < 2; k++) begin
                    free_at[k] = 0; commit_at[k] = -1; exp_rdata[k] = '0; exp_err[k] = 1'b0;
                end
            end else begin
                mcur = cyc;
                cyc  = cyc + 1;
                for (int k = 0; k < 2; k++) begin
                    if (mcur >= free_at[k] && req[k]) begin
                        p_we[k] = we[k]; p_addr[k] = addr[k]; p_wdata[k] = wdata[k];
                        commit_at[k] = cyc + ws(k);
                        free_at[k]   = cyc + ws(k) + 1;
                    end
                    if (cyc == commit_at[k]) begin
                        me   = addr_err(p_addr[k], AB);
                        midx = p_addr[k][AB+1:2];
                        exp_err[k] = me;
                        if (p_we[k]) begin
                            if (!me) mem_m[k][midx] = p_wdata[k];
                        end else begin
                            exp_rdata[k] = me ? 32'h0 : mem_m[k][midx];
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ready[%0d]", k), 32'(ready[k]), 32'(cyc >= free_at[k]));
                chk($sformatf("done[%0d]", k), 32'(done[k]), 32'(cyc == commit_at[k]));
                chk($sformatf("rdata[%0d]", k), rdata[k], exp_rdata[k]);
                if (cyc == commit_at[k]) chk($sformatf("err[%0d]", k), 32'(err[k]), 32'(exp_err[k]));
            end
        end
    end

    // One transaction: wait until free, present for one edge, scramble the inputs,
    // then wait (bounded) for done and report latency in edges, data and err.
    task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
        int  n;
        int  acc;
        bit  got;
        n = 0; got = 0; lat = -1; rd = 'x; er = 1'bx;
        @(posedge clk); #3;
        while (cyc < free_at[k] && n < 50) begin @(posedge clk); #3; n++; end
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        @(posedge clk); #1;
        acc = cyc;
        #2;
        req[k] = 1'b0; we[k] = ~w; addr[k] = ~a; wdata[k] = ~d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done[k]) begin lat = cyc - acc + 1; rd = rdata[k]; er = err[k]; got = 1; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout[%0d]: no done for addr %h, required within 20 cycles", k, a);
        end
    endtask

    int          lat, ndone;
    logic [31:0] rd;
    logic        er;

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
        end
        @(negedge clk);
        chk("ready in reset", 32'(ready[0]), 32'd1);
        repeat (3) @(posedge clk);
        #3 clrn = 1'b1;
        @(negedge clk);
        chk("reset ready", 32'(ready[0]), 32'd1);
        chk("reset done",  32'(done[0]),  32'd0);
        chk("reset err",   32'(err[0]),   32'd0);
        chk("reset rdata", rdata[0],      32'd0);

        // Known contents everywhere; word 3 (0xC) stays zero.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++)
                xact(k, 1'b1, 32'(i * 4), (i == 3) ? 32'h0 : (32'hC0DE0000 | 32'(i)), lat, rd, er);

        xact(0, 1'b1, 32'h8, 32'hDEADBEEF, lat, rd, er);
        chk("ws2 store lat", 32'(lat), 32'd3);
        chk("ws2 store err", 32'(er),  32'd0);
        xact(0, 1'b0, 32'h8, 32'h0, lat, rd, er);
        chk("ws2 load lat",   32'(lat), 32'd3);
        chk("ws2 load rdata", rd,       32'hDEADBEEF);
        chk("ws2 load err",   32'(er),  32'd0);

        xact(0, 1'b0, 32'h6, 32'h0, lat, rd, er);
        chk("misaligned err",   32'(er), 32'd1);
        chk("misaligned rdata", rd,      32'd0);
        xact(0, 1'b0, 32'h80, 32'h0, lat, rd, er);
        chk("range err",   32'(er), 32'd1);
        chk("range rdata", rd,      32'd0);
        xact(0, 1'b0, 32'h4, 32'h0, lat, rd, er);
        chk("after err load", rd, 32'hC0DE0001);
        xact(0, 1'b1, 32'h9, 32'h55, lat, rd, er);
        chk("bad store err", 32'(er), 32'd1);
        xact(0, 1'b0, 32'h8, 32'h0, lat, rd, er);
        chk("bad store no write", rd, 32'hDEADBEEF);
        xact(0, 1'b1, 32'h10, 32'h0BADF00D, lat, rd, er);
        chk("store keeps rdata", rd, 32'hDEADBEEF);

        // req held high with an address that moves every cycle.
        ndone = 0;
        @(posedge clk); #3;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done[0]) ndone++;
            @(posedge clk); #3;
            addr[0] = addr[0] + 32'd4;
        end
        req[0] = 1'b0;
        chk("stream done count", 32'(ndone), 32'd4);
        chk("stream last rdata", rdata[0],   32'hC0DE000C);

        xact(1, 1'b1, 32'h0, 32'h12345678, lat, rd, er);
        chk("ws0 store lat", 32'(lat), 32'd1);
        xact(1, 1'b0, 32'h0, 32'h0, lat, rd, er);
        chk("ws0 load lat",   32'(lat), 32'd1);
        chk("ws0 load rdata", rd,       32'h12345678);
        xact(1, 1'b0, 32'h7C, 32'h0, lat, rd, er);
        chk("ws0 top word", rd,       32'hC0DE001F);
        chk("ws0 top err",  32'(er),  32'd0);
        xact(1, 1'b0, 32'h80, 32'h0, lat, rd, er);
        chk("ws0 range err", 32'(er), 32'd1);

        // Reset while the store sits in WAIT: it must neither complete nor commit.
        @(posedge clk); #3;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'hC; wdata[0] = 32'hA5A5A5A5;
        @(posedge clk); #3;
        req[0] = 1'b0;
        @(posedge clk); #3;
        clrn = 1'b0;
        ndone = 0;
        @(posedge clk); #3;
        clrn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk("abandoned done",  32'(ndone), 32'd0);
        chk("rdata after rst", rdata[0],   32'd0);
        xact(0, 1'b0, 32'hC, 32'h0, lat, rd, er);
        chk("abandoned store", rd,      32'h0);
        chk("abandoned err",   32'(er), 32'd0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
